// File: rtl/reg_wb_arbiter.sv
// reg_wb_arbiter: shares the register-file write port between the pipeline (A, fixed priority)
// and a FIFO-buffered auxiliary writer (B) with a starvation guard and pending-read flags.
module reg_wb_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8,
    parameter int ADDR_W       = 5,
    parameter int DATA_W       = 32,
    localparam int CW          = $clog2(DEPTH) + 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              A_VALID,
    input  logic [ADDR_W-1:0] A_ADDR,
    input  logic [DATA_W-1:0] A_DATA,
    output logic              A_STALL,
    input  logic              B_VALID,
    output logic              B_READY,
    input  logic [ADDR_W-1:0] B_ADDR,
    input  logic [DATA_W-1:0] B_DATA,
    output logic              REG_WRITE_EN,
    output logic [ADDR_W-1:0] REG_INADDRESS,
    output logic [DATA_W-1:0] REG_DATA_IN,
    input  logic [ADDR_W-1:0] RD1_ADDR,
    input  logic [ADDR_W-1:0] RD2_ADDR,
    output logic              RD1_PENDING,
    output logic              RD2_PENDING,
    output logic [CW-1:0]     FIFO_COUNT
);
    localparam int PW = $clog2(DEPTH);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [PW-1:0]     rd_ptr, wr_ptr;
    logic [CW-1:0]     count;
    logic [SW-1:0]     starve;
    logic              nonempty, starve_fire, grant_a, grant_b, push;
    logic              hit1, hit2;

    assign B_READY     = !RESET && (count < CW'(DEPTH));
    assign push        = B_VALID && B_READY && (B_ADDR != '0);
    assign nonempty    = count != '0;
    assign starve_fire = (starve == SW'(STARVE_LIMIT)) && nonempty;
    assign grant_a     = !starve_fire && A_VALID && (A_ADDR != '0);
    assign grant_b     = nonempty && !grant_a;
    assign A_STALL     = starve_fire;
    assign FIFO_COUNT  = count;

    always_ff @(posedge CLK) begin
        if (push) begin
            addr_q[wr_ptr] <= B_ADDR;
            data_q[wr_ptr] <= B_DATA;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            REG_WRITE_EN  <= 1'b0;
            REG_INADDRESS <= '0;
            REG_DATA_IN   <= '0;
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            count         <= '0;
            starve        <= '0;
        end else begin
            REG_WRITE_EN  <= grant_a || grant_b;
            REG_INADDRESS <= grant_a ? A_ADDR : grant_b ? addr_q[rd_ptr] : REG_INADDRESS;
            REG_DATA_IN   <= grant_a ? A_DATA : grant_b ? data_q[rd_ptr] : REG_DATA_IN;
            wr_ptr        <= push ? wr_ptr + PW'(1) : wr_ptr;
            rd_ptr        <= grant_b ? rd_ptr + PW'(1) : rd_ptr;
            count         <= count + CW'(push) - CW'(grant_b);
            starve        <= (grant_b || !nonempty) ? '0 :
                             (grant_a && starve != SW'(STARVE_LIMIT)) ? starve + SW'(1) : starve;
        end
    end

    // Only entries between rd_ptr and rd_ptr+count are live; stale slots must not match.
    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            hit1 = hit1 | ((CW'(i) < count) && (addr_q[rd_ptr + PW'(i)] == RD1_ADDR));
            hit2 = hit2 | ((CW'(i) < count) && (addr_q[rd_ptr + PW'(i)] == RD2_ADDR));
        end
        RD1_PENDING = hit1 && (RD1_ADDR != '0);
        RD2_PENDING = hit2 && (RD2_ADDR != '0);
    end
endmodule

// File: tb/tb_reg_wb_arbiter.sv
// tb_reg_wb_arbiter: directed vectors with hand-computed expectations for reg_wb_arbiter.
module tb_reg_wb_arbiter;
    logic        CLK = 1'b0;
    logic        RESET;
    logic        A_VALID, A_STALL, B_VALID, B_READY;
    logic [4:0]  A_ADDR, B_ADDR, REG_INADDRESS, RD1_ADDR, RD2_ADDR;
    logic [31:0] A_DATA, B_DATA, REG_DATA_IN;
    logic        REG_WRITE_EN, RD1_PENDING, RD2_PENDING;
    logic [2:0]  FIFO_COUNT;
    int          checks = 0;
    int          errors = 0;

    reg_wb_arbiter dut (
        .CLK(CLK), .RESET(RESET),
        .A_VALID(A_VALID), .A_ADDR(A_ADDR), .A_DATA(A_DATA), .A_STALL(A_STALL),
        .B_VALID(B_VALID), .B_READY(B_READY), .B_ADDR(B_ADDR), .B_DATA(B_DATA),
        .REG_WRITE_EN(REG_WRITE_EN), .REG_INADDRESS(REG_INADDRESS), .REG_DATA_IN(REG_DATA_IN),
        .RD1_ADDR(RD1_ADDR), .RD2_ADDR(RD2_ADDR),
        .RD1_PENDING(RD1_PENDING), .RD2_PENDING(RD2_PENDING), .FIFO_COUNT(FIFO_COUNT)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic expect_write(input string tag, input logic [4:0] a, input logic [31:0] d);
        check({tag, "_we"}, 32'(REG_WRITE_EN), 32'd1);
        check({tag, "_addr"}, 32'(REG_INADDRESS), 32'(a));
        check({tag, "_data"}, REG_DATA_IN, d);
    endtask

    initial begin
        RESET = 1'b1; A_VALID = 1'b0; A_ADDR = '0; A_DATA = '0;
        B_VALID = 1'b0; B_ADDR = '0; B_DATA = '0; RD1_ADDR = '0; RD2_ADDR = '0;
        tick();
        tick();
        check("rst_we", 32'(REG_WRITE_EN), 32'd0);
        check("rst_addr", 32'(REG_INADDRESS), 32'd0);
        check("rst_data", REG_DATA_IN, 32'd0);
        check("rst_count", 32'(FIFO_COUNT), 32'd0);
        check("rst_bready", 32'(B_READY), 32'd0);
        RESET = 1'b0;
        #1;
        check("bready_after_rst", 32'(B_READY), 32'd1);

        // single A write
        A_VALID = 1'b1; A_ADDR = 5'd1; A_DATA = 32'h12345678;
        #1;
        check("a_stall_idle", 32'(A_STALL), 32'd0);
        tick();
        A_VALID = 1'b0;
        expect_write("a1", 5'd1, 32'h12345678);
        tick();
        check("a1_we_off", 32'(REG_WRITE_EN), 32'd0);
        check("a1_addr_hold", 32'(REG_INADDRESS), 32'd1);

        // single B write, two-cycle latency, pending flag
        B_VALID = 1'b1; B_ADDR = 5'd3; B_DATA = 32'hABCDEFF0; RD1_ADDR = 5'd3;
        #1;
        check("b1_pend_pre", 32'(RD1_PENDING), 32'd0);
        tick();
        B_VALID = 1'b0;
        #1;
        check("b1_count", 32'(FIFO_COUNT), 32'd1);
        check("b1_pend", 32'(RD1_PENDING), 32'd1);
        check("b1_no_bypass", 32'(REG_WRITE_EN), 32'd0);
        tick();
        expect_write("b1", 5'd3, 32'hABCDEFF0);
        check("b1_count_after", 32'(FIFO_COUNT), 32'd0);
        check("b1_pend_after", 32'(RD1_PENDING), 32'd0);
        tick();
        check("b1_we_off", 32'(REG_WRITE_EN), 32'd0);

        // starvation: A held on addr 2 while B fills with 4..7
        A_VALID = 1'b1; A_ADDR = 5'd2; A_DATA = 32'h22;
        for (int i = 0; i < 4; i++) begin
            B_VALID = 1'b1; B_ADDR = 5'(4 + i); B_DATA = 32'h40 + 32'(i) * 32'h10;
            tick();
            expect_write("starve_fill", 5'd2, 32'h22);
        end
        B_VALID = 1'b0;
        check("full_bready", 32'(B_READY), 32'd0);
        check("full_count", 32'(FIFO_COUNT), 32'd4);
        for (int i = 0; i < 5; i++) begin
            check("no_stall_yet", 32'(A_STALL), 32'd0);
            tick();
            expect_write("a_hold", 5'd2, 32'h22);
        end
        RD1_ADDR = 5'd9; RD2_ADDR = 5'd6;
        #1;
        check("starve_fire", 32'(A_STALL), 32'd1);
        check("rd2_pend_6", 32'(RD2_PENDING), 32'd1);
        check("rd1_pend_9", 32'(RD1_PENDING), 32'd0);
        tick();
        expect_write("starve_b", 5'd4, 32'h40);
        check("stall_released", 32'(A_STALL), 32'd0);
        check("starve_count", 32'(FIFO_COUNT), 32'd3);
        tick();
        A_VALID = 1'b0;
        expect_write("held_a", 5'd2, 32'h22);
        tick();
        expect_write("drain5", 5'd5, 32'h50);
        tick();
        expect_write("drain6", 5'd6, 32'h60);
        check("rd2_pend_drained", 32'(RD2_PENDING), 32'd0);
        tick();
        expect_write("drain7", 5'd7, 32'h70);
        check("drain_count", 32'(FIFO_COUNT), 32'd0);
        tick();

        // x0 filtering
        A_VALID = 1'b1; A_ADDR = 5'd0; A_DATA = 32'h98765432;
        B_VALID = 1'b1; B_ADDR = 5'd0; B_DATA = 32'h1;
        #1;
        check("x0_stall", 32'(A_STALL), 32'd0);
        check("x0_bready", 32'(B_READY), 32'd1);
        tick();
        A_VALID = 1'b0; B_VALID = 1'b0;
        check("x0_we", 32'(REG_WRITE_EN), 32'd0);
        check("x0_count", 32'(FIFO_COUNT), 32'd0);
        tick();
        check("x0_we2", 32'(REG_WRITE_EN), 32'd0);

        // reset with three queued entries
        A_VALID = 1'b1; A_ADDR = 5'd12; A_DATA = 32'hC;
        for (int i = 0; i < 3; i++) begin
            B_VALID = 1'b1; B_ADDR = 5'(9 + i); B_DATA = 32'(9 + i);
            tick();
        end
        check("pre_rst_count", 32'(FIFO_COUNT), 32'd3);
        RESET = 1'b1; A_VALID = 1'b0; B_VALID = 1'b0;
        #1;
        check("mid_rst_bready", 32'(B_READY), 32'd0);
        tick();
        check("mid_rst_count", 32'(FIFO_COUNT), 32'd0);
        check("mid_rst_we", 32'(REG_WRITE_EN), 32'd0);
        RESET = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("post_rst_no_write", 32'(REG_WRITE_EN), 32'd0);
        end

        // full FIFO with B_VALID held across a pop
        A_VALID = 1'b1; A_ADDR = 5'd13; A_DATA = 32'hD;
        for (int i = 0; i < 4; i++) begin
            B_VALID = 1'b1; B_ADDR = 5'(20 + i); B_DATA = 32'h200 + 32'(i);
            tick();
        end
        A_VALID = 1'b0;
        B_ADDR = 5'd24; B_DATA = 32'h204;
        #1;
        check("full_hold_bready", 32'(B_READY), 32'd0);
        tick();
        expect_write("pop20", 5'd20, 32'h200);
        check("no_enq_on_pop", 32'(FIFO_COUNT), 32'd3);
        check("bready_back", 32'(B_READY), 32'd1);
        tick();
        B_VALID = 1'b0;
        expect_write("pop21", 5'd21, 32'h201);
        check("enq_deq_count", 32'(FIFO_COUNT), 32'd3);
        tick();
        expect_write("pop22", 5'd22, 32'h202);
        tick();
        expect_write("pop23", 5'd23, 32'h203);
        tick();
        expect_write("pop24", 5'd24, 32'h204);
        tick();

        // pointer wrap: ten back-to-back pushes, each popped a cycle later
        for (int i = 0; i < 10; i++) begin
            B_VALID = 1'b1; B_ADDR = 5'(i + 1); B_DATA = 32'h1111 * 32'(i + 1);
            tick();
            if (i > 0) expect_write("wrap", 5'(i), 32'h1111 * 32'(i));
        end
        B_VALID = 1'b0;
        tick();
        expect_write("wrap_last", 5'd10, 32'hAAAA);
        check("wrap_count", 32'(FIFO_COUNT), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
